// File: rtl/kcpsmx_port_fifo_if.sv
// kcpsmx_port_fifo_if: core port bus, interrupt handshake and TX/RX valid/ready streams
interface kcpsmx_port_fifo_if;
    logic [7:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport slave (
        input  port_id, write_strobe, read_strobe, out_port, interrupt_ack,
        input  tx_ready, rx_data, rx_valid,
        output in_port, interrupt, tx_data, tx_valid, rx_ready
    );

    modport master (
        output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
        output tx_ready, rx_data, rx_valid,
        input  in_port, interrupt, tx_data, tx_valid, rx_ready
    );
endinterface

// File: rtl/kcpsmx_port_fifo.sv
// kcpsmx_port_fifo: port-mapped TX/RX byte FIFOs with status, control and interrupt
module kcpsmx_port_fifo #(
    parameter logic [7:0] BASE_ADDR = 8'h00,
    parameter int         DEPTH     = 16
) (
    input logic clk,
    input logic reset,
    kcpsmx_port_fifo_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [7:0] tx_mem [DEPTH];
    logic [7:0] rx_mem [DEPTH];
    logic [AW-1:0] tx_wr, tx_rd, rx_wr, rx_rd;
    logic [AW:0] tx_cnt, rx_cnt;
    logic tx_full, tx_empty, rx_full, rx_empty;
    logic tx_ovf, rx_ovf, rx_ie, txe_ie, irq;
    logic sel_tx, sel_rx, sel_st, sel_ct;
    logic tx_push, tx_pop, rx_push, rx_pop, irq_set, ctl_wr;
    logic [7:0] status, rd_mux;

    assign sel_tx = bus.port_id == BASE_ADDR;
    assign sel_rx = bus.port_id == BASE_ADDR + 8'd1;
    assign sel_st = bus.port_id == BASE_ADDR + 8'd2;
    assign sel_ct = bus.port_id == BASE_ADDR + 8'd3;

    assign tx_full  = tx_cnt == FULL;
    assign tx_empty = tx_cnt == '0;
    assign rx_full  = rx_cnt == FULL;
    assign rx_empty = rx_cnt == '0;

    assign tx_push = bus.write_strobe & sel_tx & !tx_full;
    assign tx_pop  = !tx_empty & bus.tx_ready;
    assign rx_push = bus.rx_valid & !rx_full;
    assign rx_pop  = bus.read_strobe & sel_rx & !rx_empty;
    assign ctl_wr  = bus.write_strobe & sel_ct;
    // A push in the same cycle keeps the count at 1, so only a lone final pop counts as "TX emptied"
    assign irq_set = (rx_push & rx_ie) | (tx_pop & !tx_push & tx_cnt == ONE & txe_ie);

    assign status = {2'b00, tx_ovf, rx_ovf, rx_empty, rx_full, tx_empty, tx_full};

    always_comb begin
        rd_mux = sel_rx ? (rx_empty ? 8'h00 : rx_mem[rx_rd]) :
                 sel_st ? status :
                 sel_ct ? {6'b0, txe_ie, rx_ie} : 8'h00;
    end

    assign bus.tx_valid  = !tx_empty;
    assign bus.tx_data   = tx_empty ? 8'h00 : tx_mem[tx_rd];
    assign bus.rx_ready  = !rx_full;
    assign bus.interrupt = irq;

    always_ff @(posedge clk) begin
        if (tx_push) tx_mem[tx_wr] <= bus.out_port;
        if (rx_push) rx_mem[rx_wr] <= bus.rx_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_wr       <= '0;
            tx_rd       <= '0;
            tx_cnt      <= '0;
            rx_wr       <= '0;
            rx_rd       <= '0;
            rx_cnt      <= '0;
            tx_ovf      <= 1'b0;
            rx_ovf      <= 1'b0;
            rx_ie       <= 1'b0;
            txe_ie      <= 1'b0;
            irq         <= 1'b0;
            bus.in_port <= 8'h00;
        end else begin
            if (tx_push) tx_wr <= tx_wr + AW'(1);
            if (tx_pop) tx_rd <= tx_rd + AW'(1);
            if (rx_push) rx_wr <= rx_wr + AW'(1);
            if (rx_pop) rx_rd <= rx_rd + AW'(1);
            tx_cnt <= tx_cnt + (AW+1)'(tx_push) - (AW+1)'(tx_pop);
            rx_cnt <= rx_cnt + (AW+1)'(rx_push) - (AW+1)'(rx_pop);
            if (ctl_wr) begin
                rx_ie  <= bus.out_port[0];
                txe_ie <= bus.out_port[1];
            end
            // Overflow events in the clearing cycle win over the clear
            tx_ovf <= (tx_ovf & !(ctl_wr & bus.out_port[7])) | (bus.write_strobe & sel_tx & tx_full);
            rx_ovf <= (rx_ovf & !(ctl_wr & bus.out_port[7])) | (bus.rx_valid & rx_full);
            irq <= irq_set | (irq & !bus.interrupt_ack);
            bus.in_port <= rd_mux;
        end
    end
endmodule

// File: tb/tb_kcpsmx_port_fifo.sv
// tb_kcpsmx_port_fifo: directed checks of register map, FIFO flow, overflow, interrupt and reset
module tb_kcpsmx_port_fifo;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int bad = 0;
    logic [7:0] v;

    kcpsmx_port_fifo_if bus();

    kcpsmx_port_fifo dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic io_wr(input logic [7:0] a, input logic [7:0] d);
        bus.port_id = a;
        bus.out_port = d;
        bus.write_strobe = 1'b1;
        tick();
        bus.write_strobe = 1'b0;
    endtask

    task automatic io_rd(input logic [7:0] a, output logic [7:0] d);
        bus.port_id = a;
        bus.read_strobe = 1'b1;
        tick();
        bus.read_strobe = 1'b0;
        d = bus.in_port;
    endtask

    task automatic rx_put(input logic [7:0] d);
        bus.rx_data = d;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic ack();
        bus.interrupt_ack = 1'b1;
        tick();
        bus.interrupt_ack = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.port_id = 8'h10;
        bus.write_strobe = 1'b0;
        bus.read_strobe = 1'b0;
        bus.out_port = 8'h00;
        bus.interrupt_ack = 1'b0;
        bus.tx_ready = 1'b0;
        bus.rx_data = 8'h00;
        bus.rx_valid = 1'b0;
        tick();
        tick();
        chk("rst in_port", bus.in_port, 8'h00);
        chk("rst interrupt", 8'(bus.interrupt), 8'h00);
        chk("rst tx_valid", 8'(bus.tx_valid), 8'h00);
        chk("rst rx_ready", 8'(bus.rx_ready), 8'h01);
        chk("rst tx_data", bus.tx_data, 8'h00);
        reset = 1'b0;
        tick();

        // TX buffering and drain
        io_wr(8'h00, 8'hA5);
        chk("t1 tx_valid latency", 8'(bus.tx_valid), 8'h01);
        io_wr(8'h00, 8'h3C);
        chk("t1 tx_data head", bus.tx_data, 8'hA5);
        io_rd(8'h02, v);
        chk("t1 status busy", v, 8'h08);
        bus.tx_ready = 1'b1;
        tick();
        chk("t1 tx_data second", bus.tx_data, 8'h3C);
        chk("t1 tx_valid mid", 8'(bus.tx_valid), 8'h01);
        tick();
        chk("t1 tx_valid drained", 8'(bus.tx_valid), 8'h00);
        chk("t1 tx_data empty", bus.tx_data, 8'h00);
        bus.tx_ready = 1'b0;
        io_rd(8'h02, v);
        chk("t1 status idle", v, 8'h0A);

        // TX overflow, in-order drain, flag clear
        for (int i = 0; i < 17; i++) io_wr(8'h00, 8'(8'h40 + i));
        io_rd(8'h02, v);
        chk("t2 status full ovf", v, 8'h29);
        bus.tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t2 drain data", bus.tx_data, 8'(8'h40 + i));
            tick();
        end
        chk("t2 drained", 8'(bus.tx_valid), 8'h00);
        bus.tx_ready = 1'b0;
        io_wr(8'h03, 8'h80);
        io_rd(8'h02, v);
        chk("t2 ovf cleared", v, 8'h0A);
        io_rd(8'h03, v);
        chk("t2 control reads 0", v, 8'h00);

        // RX push with interrupt, pop, ack
        io_wr(8'h03, 8'h01);
        rx_put(8'h11);
        chk("t3 interrupt set", 8'(bus.interrupt), 8'h01);
        io_rd(8'h03, v);
        chk("t3 control", v, 8'h01);
        io_rd(8'h01, v);
        chk("t3 rx data", v, 8'h11);
        io_rd(8'h02, v);
        chk("t3 status", v, 8'h0A);
        ack();
        chk("t3 interrupt ack", 8'(bus.interrupt), 8'h00);

        // TX-empty interrupt and set-vs-ack priority
        io_wr(8'h03, 8'h02);
        io_wr(8'h00, 8'h77);
        chk("t4 no irq yet", 8'(bus.interrupt), 8'h00);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;
        chk("t4 tx empty", 8'(bus.tx_valid), 8'h00);
        chk("t4 txe irq", 8'(bus.interrupt), 8'h01);
        ack();
        chk("t4 ack clears", 8'(bus.interrupt), 8'h00);
        io_wr(8'h03, 8'h03);
        bus.interrupt_ack = 1'b1;
        rx_put(8'h22);
        bus.interrupt_ack = 1'b0;
        chk("t4 set wins", 8'(bus.interrupt), 8'h01);
        io_wr(8'h03, 8'h00);
        chk("t4 ie clear keeps pending", 8'(bus.interrupt), 8'h01);
        ack();
        chk("t4 final ack", 8'(bus.interrupt), 8'h00);
        io_rd(8'h01, v);
        chk("t4 rx data", v, 8'h22);

        // RX fill across pointer wrap, overflow, ordered pops
        for (int i = 0; i < 16; i++) rx_put(8'(i));
        chk("t5 rx_ready full", 8'(bus.rx_ready), 8'h00);
        io_rd(8'h02, v);
        chk("t5 status full", v, 8'h06);
        rx_put(8'hEE);
        io_rd(8'h02, v);
        chk("t5 status ovf", v, 8'h16);
        for (int i = 0; i < 16; i++) begin
            io_rd(8'h01, v);
            chk("t5 pop order", v, 8'(i));
        end
        io_rd(8'h01, v);
        chk("t5 pop empty", v, 8'h00);
        io_rd(8'h02, v);
        chk("t5 status empty ovf", v, 8'h1A);
        io_wr(8'h03, 8'h80);
        io_rd(8'h02, v);
        chk("t5 ovf cleared", v, 8'h0A);
        io_rd(8'h07, v);
        chk("unmapped read", v, 8'h00);
        io_wr(8'h05, 8'h99);
        chk("unmapped write", 8'(bus.tx_valid), 8'h00);

        // Asynchronous reset with both FIFOs half full
        io_wr(8'h03, 8'h01);
        for (int i = 0; i < 8; i++) io_wr(8'h00, 8'(8'hC0 + i));
        for (int i = 0; i < 8; i++) rx_put(8'(8'h80 + i));
        bus.port_id = 8'h01;
        tick();
        chk("t6 pre in_port", bus.in_port, 8'h80);
        chk("t6 pre interrupt", 8'(bus.interrupt), 8'h01);
        #2;
        reset = 1'b1;
        #1;
        chk("t6 in_port", bus.in_port, 8'h00);
        chk("t6 interrupt", 8'(bus.interrupt), 8'h00);
        chk("t6 tx_valid", 8'(bus.tx_valid), 8'h00);
        chk("t6 tx_data", bus.tx_data, 8'h00);
        chk("t6 rx_ready", 8'(bus.rx_ready), 8'h01);
        tick();
        reset = 1'b0;
        io_rd(8'h02, v);
        chk("t6 status", v, 8'h0A);
        io_rd(8'h03, v);
        chk("t6 control", v, 8'h00);
        io_rd(8'h01, v);
        chk("t6 rx empty", v, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
